// File: rtl/switch_csr_mailbox.sv
// Avalon-MM CSR/mailbox slave: holds the switch control register, queues host words to the
// ingress ports through per-port TX FIFOs and one arbitrated output slot, and queues egress words in polled RX FIFOs.
module switch_csr_mailbox #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int TX_DEPTH  = 4,
    parameter int RX_DEPTH  = 4,
    parameter int ADDR_W    = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        chipselect,
    input  logic                        write,
    input  logic                        read,
    input  logic [ADDR_W-1:0]           address,
    input  logic [DATA_W-1:0]           writedata,
    output logic [DATA_W-1:0]           readdata,
    output logic [DATA_W-1:0]           interface_out,
    output logic [NUM_PORTS-1:0]        interface_out_en,
    input  logic [NUM_PORTS-1:0]        interface_out_ready,
    input  logic [NUM_PORTS*DATA_W-1:0] interface_in,
    input  logic [NUM_PORTS-1:0]        interface_in_valid,
    output logic [NUM_PORTS-1:0]        interface_in_ready,
    output logic [NUM_PORTS-1:0]        interface_out_ack,
    output logic                        experimenting,
    output logic                        simple_reset,
    output logic                        sched_policy,
    output logic [7:0]                  sched_prio
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TA = $clog2(TX_DEPTH);
    localparam int RA = $clog2(RX_DEPTH);

    logic [DATA_W-1:0]    ctrl;
    logic [DATA_W-1:0]    status;
    logic                 read_q;
    logic                 flush;
    logic                 ctrl_wr;
    logic                 ovf_clr;
    logic                 rd_edge;
    logic                 port_hit;
    logic [PW-1:0]        port_sel;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        grant;
    logic                 grant_vld;
    logic                 slot_free;
    logic [NUM_PORTS-1:0] tx_full, tx_empty, tx_push_req, tx_push, tx_pop, tx_ovf_set, tx_ovf;
    logic [NUM_PORTS-1:0] rx_full, rx_empty, rx_push, rx_pop, rx_ovf_set, rx_ovf;
    logic [DATA_W-1:0]    tx_head [NUM_PORTS];
    logic [DATA_W-1:0]    rx_head [NUM_PORTS];

    assign flush         = (ctrl[1:0] == 2'd0);
    assign experimenting = (ctrl[1:0] == 2'd2);
    assign simple_reset  = flush || !reset_n;
    assign sched_policy  = ctrl[2];
    assign sched_prio    = ctrl[10:3];

    assign ctrl_wr = chipselect && write && (address == '0);
    assign ovf_clr = ctrl_wr && writedata[11];
    assign rd_edge = chipselect && read && !read_q;

    always_comb begin
        port_hit = 1'b0;
        port_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (address == ADDR_W'(i + 2)) begin
                port_hit = 1'b1;
                port_sel = PW'(i);
            end
        end
    end

    always_comb begin
        status = '0;
        status[NUM_PORTS-1:0]             = tx_full;
        status[2*NUM_PORTS-1:NUM_PORTS]   = ~rx_empty;
        status[3*NUM_PORTS-1:2*NUM_PORTS] = tx_ovf;
        status[4*NUM_PORTS-1:3*NUM_PORTS] = rx_ovf;
    end

    // The slot reloads when empty or when its current word is being accepted this cycle.
    assign slot_free = !(|interface_out_en) || (|(interface_out_en & interface_out_ready));

    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] cand;
        sum       = '0;
        cand      = '0;
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_PORTS)) sum = sum - (PW+1)'(NUM_PORTS);
            cand = sum[PW-1:0];
            if (!grant_vld && !tx_empty[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [DATA_W-1:0] tx_mem [TX_DEPTH];
        logic [TA-1:0]     tx_wp, tx_rp;
        logic [TA:0]       tx_cnt;
        logic [DATA_W-1:0] rx_mem [RX_DEPTH];
        logic [RA-1:0]     rx_wp, rx_rp;
        logic [RA:0]       rx_cnt;

        assign tx_full[i]     = (tx_cnt == (TA+1)'(TX_DEPTH));
        assign tx_empty[i]    = (tx_cnt == '0);
        assign tx_head[i]     = tx_mem[tx_rp];
        assign tx_push_req[i] = chipselect && write && (address == ADDR_W'(i + 2));
        assign tx_pop[i]      = slot_free && grant_vld && !flush && (grant == PW'(i));
        assign tx_push[i]     = tx_push_req[i] && !flush && (!tx_full[i] || tx_pop[i]);
        assign tx_ovf_set[i]  = tx_push_req[i] && !flush && tx_full[i] && !tx_pop[i];

        assign rx_full[i]     = (rx_cnt == (RA+1)'(RX_DEPTH));
        assign rx_empty[i]    = (rx_cnt == '0);
        assign rx_head[i]     = rx_mem[rx_rp];
        assign rx_pop[i]      = rd_edge && port_hit && (port_sel == PW'(i)) && !rx_empty[i] && !flush;
        assign rx_push[i]     = interface_in_valid[i] && !flush && (!rx_full[i] || rx_pop[i]);
        assign rx_ovf_set[i]  = interface_in_valid[i] && !flush && rx_full[i] && !rx_pop[i];
        assign interface_in_ready[i] = !rx_full[i];

        always_ff @(posedge clk) begin
            if (tx_push[i]) tx_mem[tx_wp] <= writedata;
            if (rx_push[i]) rx_mem[rx_wp] <= interface_in[i*DATA_W +: DATA_W];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n || flush) begin
                tx_wp  <= '0;
                tx_rp  <= '0;
                tx_cnt <= '0;
                rx_wp  <= '0;
                rx_rp  <= '0;
                rx_cnt <= '0;
            end else begin
                if (tx_push[i]) tx_wp <= tx_wp + 1'b1;
                if (tx_pop[i])  tx_rp <= tx_rp + 1'b1;
                case ({tx_push[i], tx_pop[i]})
                    2'b10:   tx_cnt <= tx_cnt + 1'b1;
                    2'b01:   tx_cnt <= tx_cnt - 1'b1;
                    default: ;
                endcase
                if (rx_push[i]) rx_wp <= rx_wp + 1'b1;
                if (rx_pop[i])  rx_rp <= rx_rp + 1'b1;
                case ({rx_push[i], rx_pop[i]})
                    2'b10:   rx_cnt <= rx_cnt + 1'b1;
                    2'b01:   rx_cnt <= rx_cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl              <= '0;
            read_q            <= 1'b0;
            readdata          <= '0;
            interface_out     <= '0;
            interface_out_en  <= '0;
            interface_out_ack <= '0;
            rr_ptr            <= '0;
            tx_ovf            <= '0;
            rx_ovf            <= '0;
        end else begin
            read_q            <= read;
            interface_out_ack <= rx_pop;
            // Bit 11 is a clear strobe, never stored; a new overflow in the same cycle wins.
            if (ctrl_wr) begin
                ctrl     <= writedata;
                ctrl[11] <= 1'b0;
            end
            tx_ovf <= (ovf_clr ? '0 : tx_ovf) | tx_ovf_set;
            rx_ovf <= (ovf_clr ? '0 : rx_ovf) | rx_ovf_set;

            if (rd_edge) begin
                if (address == '0)
                    readdata <= ctrl;
                else if (address == ADDR_W'(1))
                    readdata <= status;
                else if (port_hit && !rx_empty[port_sel] && !flush)
                    readdata <= rx_head[port_sel];
                else
                    readdata <= '0;
            end

            if (flush) begin
                interface_out    <= '0;
                interface_out_en <= '0;
            end else if (slot_free) begin
                if (grant_vld) begin
                    interface_out    <= tx_head[grant];
                    interface_out_en <= NUM_PORTS'(1) << grant;
                    rr_ptr           <= (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
                end else begin
                    interface_out_en <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_switch_csr_mailbox.sv
// Directed bench for switch_csr_mailbox: register decode, TX arbitration, RX polling,
// overflow handling, flush mode and asynchronous reset.
`timescale 1ns/1ps
module tb_switch_csr_mailbox;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            chipselect = 1'b0;
    logic            write = 1'b0;
    logic            read = 1'b0;
    logic [AW-1:0]   address = '0;
    logic [DW-1:0]   writedata = '0;
    logic [DW-1:0]   readdata;
    logic [DW-1:0]   interface_out;
    logic [N-1:0]    interface_out_en;
    logic [N-1:0]    interface_out_ready = '1;
    logic [N*DW-1:0] interface_in = '0;
    logic [N-1:0]    interface_in_valid = '0;
    logic [N-1:0]    interface_in_ready;
    logic [N-1:0]    interface_out_ack;
    logic            experimenting, simple_reset, sched_policy;
    logic [7:0]      sched_prio;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] rd;
    logic [N-1:0]  ak;

    switch_csr_mailbox dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .interface_out(interface_out), .interface_out_en(interface_out_en),
        .interface_out_ready(interface_out_ready), .interface_in(interface_in),
        .interface_in_valid(interface_in_valid), .interface_in_ready(interface_in_ready),
        .interface_out_ack(interface_out_ack), .experimenting(experimenting),
        .simple_reset(simple_reset), .sched_policy(sched_policy), .sched_prio(sched_prio)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    // One idle cycle guarantees a fresh rising edge of read.
    task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [N-1:0] k);
        chipselect = 1'b0; read = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata; k = interface_out_ack;
    endtask

    task automatic rx_push(input int p, input logic [DW-1:0] d);
        interface_in[p*DW +: DW] = d;
        interface_in_valid[p] = 1'b1;
        @(posedge clk); #1;
        interface_in_valid = '0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (simple_reset !== 1'b1) begin n_bad++; $display("FAIL reset_simple_in_reset: got %b want 1", simple_reset); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        n_cmp++; if (interface_in_ready !== 4'hF) begin n_bad++; $display("FAIL reset_in_ready: got %h want f", interface_in_ready); end
        n_cmp++; if (interface_out_en !== 4'h0) begin n_bad++; $display("FAIL reset_out_en: got %h want 0", interface_out_en); end
        bus_read(4'd1, rd, ak);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h want 0", rd); end
        bus_read(4'd0, rd, ak);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h want 0", rd); end
        n_cmp++; if (simple_reset !== 1'b1) begin n_bad++; $display("FAIL reset_simple_mode0: got %b want 1", simple_reset); end
    endtask

    task automatic test_ctrl_decode();
        bus_write(4'd0, 32'h0000_042E);
        n_cmp++; if (experimenting !== 1'b1) begin n_bad++; $display("FAIL ctrl_experimenting: got %b want 1", experimenting); end
        n_cmp++; if (sched_policy !== 1'b1) begin n_bad++; $display("FAIL ctrl_policy: got %b want 1", sched_policy); end
        n_cmp++; if (sched_prio !== 8'h85) begin n_bad++; $display("FAIL ctrl_prio: got %h want 85", sched_prio); end
        n_cmp++; if (simple_reset !== 1'b0) begin n_bad++; $display("FAIL ctrl_simple: got %b want 0", simple_reset); end
        bus_read(4'd0, rd, ak);
        n_cmp++; if (rd !== 32'h0000_042E) begin n_bad++; $display("FAIL ctrl_readback: got %h want 42e", rd); end
        bus_write(4'd9, 32'hDEAD_BEEF);
        bus_read(4'd9, rd, ak);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL unmapped_read: got %h want 0", rd); end
        bus_read(4'd1, rd, ak);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL unmapped_write_status: got %h want 0", rd); end
    endtask

    task automatic test_tx_round_robin();
        interface_out_ready = 4'h0;
        bus_write(4'd5, 32'hD0);   // parks a port-3 word so the pointer moves on to port 0
        bus_write(4'd4, 32'hA0);
        bus_write(4'd2, 32'hB0);
        bus_write(4'd4, 32'hC0);
        n_cmp++; if (interface_out_en !== 4'b1000 || interface_out !== 32'hD0) begin n_bad++; $display("FAIL rr_parked: got %b/%h want 1000/d0", interface_out_en, interface_out); end
        interface_out_ready = 4'hF;
        @(posedge clk); #1;
        n_cmp++; if (interface_out_en !== 4'b0001 || interface_out !== 32'hB0) begin n_bad++; $display("FAIL rr_first: got %b/%h want 0001/b0", interface_out_en, interface_out); end
        @(posedge clk); #1;
        n_cmp++; if (interface_out_en !== 4'b0100 || interface_out !== 32'hA0) begin n_bad++; $display("FAIL rr_second: got %b/%h want 0100/a0", interface_out_en, interface_out); end
        @(posedge clk); #1;
        n_cmp++; if (interface_out_en !== 4'b0100 || interface_out !== 32'hC0) begin n_bad++; $display("FAIL rr_third: got %b/%h want 0100/c0", interface_out_en, interface_out); end
        @(posedge clk); #1;
        n_cmp++; if (interface_out_en !== 4'b0000) begin n_bad++; $display("FAIL rr_idle: got %b want 0000", interface_out_en); end
    endtask

    task automatic test_tx_stall_overflow();
        interface_out_ready = 4'b1101;
        for (int w = 0; w < 5; w++) bus_write(4'd3, 32'h10 + 32'(w));
        n_cmp++; if (interface_out_en !== 4'b0010 || interface_out !== 32'h10) begin n_bad++; $display("FAIL stall_slot: got %b/%h want 0010/10", interface_out_en, interface_out); end
        bus_read(4'd1, rd, ak);
        n_cmp++; if (rd !== 32'h0000_0002) begin n_bad++; $display("FAIL stall_full: got %h want 2", rd); end
        bus_write(4'd3, 32'h15);
        bus_read(4'd1, rd, ak);
        n_cmp++; if (rd !== 32'h0000_0202) begin n_bad++; $display("FAIL tx_overflow: got %h want 202", rd); end
        n_cmp++; if (interface_out_en !== 4'b0010 || interface_out !== 32'h10) begin n_bad++; $display("FAIL stall_stable: got %b/%h want 0010/10", interface_out_en, interface_out); end
    endtask

    task automatic test_async_reset();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (interface_out_en !== 4'b0000 || interface_out !== 32'h0) begin n_bad++; $display("FAIL async_out: got %b/%h want 0000/0", interface_out_en, interface_out); end
        n_cmp++; if (simple_reset !== 1'b1) begin n_bad++; $display("FAIL async_simple: got %b want 1", simple_reset); end
        @(posedge clk); #1 reset_n = 1'b1;
        bus_read(4'd1, rd, ak);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL async_status: got %h want 0", rd); end
        bus_read(4'd0, rd, ak);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL async_ctrl: got %h want 0", rd); end
        n_cmp++; if (interface_out_en !== 4'b0000) begin n_bad++; $display("FAIL async_empty: got %b want 0000", interface_out_en); end
        interface_out_ready = 4'hF;
    endtask

    task automatic test_rx_poll();
        int acks;
        bus_write(4'd0, 32'h0000_042E);
        rx_push(3, 32'h11);
        rx_push(3, 32'h22);
        acks = 0;
        chipselect = 1'b1; read = 1'b1; address = 4'd5;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (interface_out_ack[3]) acks++;
        end
        chipselect = 1'b0; read = 1'b0;
        n_cmp++; if (readdata !== 32'h11) begin n_bad++; $display("FAIL poll_first: got %h want 11", readdata); end
        n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL poll_ack_count: got %0d want 1", acks); end
        bus_read(4'd1, rd, ak);
        n_cmp++; if (rd !== 32'h80) begin n_bad++; $display("FAIL poll_nonempty: got %h want 80", rd); end
        bus_read(4'd5, rd, ak);
        n_cmp++; if (rd !== 32'h22 || ak !== 4'b1000) begin n_bad++; $display("FAIL poll_second: got %h/%b want 22/1000", rd, ak); end
        bus_read(4'd1, rd, ak);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL poll_drained: got %h want 0", rd); end
        bus_read(4'd5, rd, ak);
        n_cmp++; if (rd !== 32'h0 || ak !== 4'b0000) begin n_bad++; $display("FAIL poll_empty: got %h/%b want 0/0000", rd, ak); end
    endtask

    task automatic test_rx_overflow();
        for (int p = 1; p <= 5; p++) rx_push(0, 32'(p));
        n_cmp++; if (interface_in_ready !== 4'b1110) begin n_bad++; $display("FAIL ovf_ready: got %b want 1110", interface_in_ready); end
        bus_read(4'd1, rd, ak);
        n_cmp++; if (rd !== 32'h1010) begin n_bad++; $display("FAIL rx_overflow: got %h want 1010", rd); end
        bus_write(4'd0, 32'h0000_0A36);
        bus_read(4'd1, rd, ak);
        n_cmp++; if (rd !== 32'h10) begin n_bad++; $display("FAIL ovf_clear: got %h want 10", rd); end
        bus_read(4'd0, rd, ak);
        n_cmp++; if (rd !== 32'h236) begin n_bad++; $display("FAIL ovf_ctrl: got %h want 236", rd); end
        n_cmp++; if (sched_prio !== 8'h46) begin n_bad++; $display("FAIL ovf_prio: got %h want 46", sched_prio); end
        bus_read(4'd2, rd, ak);
        n_cmp++; if (rd !== 32'h1 || ak !== 4'b0001) begin n_bad++; $display("FAIL ovf_head: got %h/%b want 1/0001", rd, ak); end
    endtask

    task automatic test_flush();
        bus_write(4'd0, 32'h4);
        n_cmp++; if (simple_reset !== 1'b1) begin n_bad++; $display("FAIL flush_simple: got %b want 1", simple_reset); end
        bus_write(4'd2, 32'h77);
        rx_push(1, 32'h99);
        bus_read(4'd1, rd, ak);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL flush_status: got %h want 0", rd); end
        n_cmp++; if (interface_in_ready !== 4'hF || interface_out_en !== 4'h0) begin n_bad++; $display("FAIL flush_ports: got %h/%h want f/0", interface_in_ready, interface_out_en); end
        bus_read(4'd0, rd, ak);
        n_cmp++; if (rd !== 32'h4) begin n_bad++; $display("FAIL flush_ctrl_kept: got %h want 4", rd); end
        bus_write(4'd0, 32'h2);
        bus_read(4'd1, rd, ak);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL flush_exit_status: got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_ctrl_decode();
        test_tx_round_robin();
        test_tx_stall_overflow();
        test_async_reset();
        test_rx_poll();
        test_rx_overflow();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
